dram_wr_rd_sequencer: RTL and testbench
=======================================

// Module: dram_wr_rd_sequencer
// PURPOSE
//   Self-test sequencer for the 16-core DRAM write/read datapath (DRAM_write_read_16core).
//   For each row in a range, it writes an address-dependent pattern to all 16 cores and reads it back.
//   It compares the 16 returned bytes, counts mismatching bytes and reports pass/fail.
//   It sits between the top-level test wrapper and the 16-core datapath, and drives IO_EN/IO_MODEL/WWL_ADD/RWL_DEC_ADD/WBL_DATA.
// PARAMETERS
//   ADDR_START   6'd0       first row address swept
//   ADDR_END     6'd63      last row address swept (inclusive, >= ADDR_START)
//   SEED         8'h55      pattern seed byte
//   TIMEOUT_CYC  4096       max cycles waited for wt_done/rd_done per operation
//   ERR_W        12         width of the error counter
// PORTS
//   clk_100m     in   1      system clock, 100 MHz
//   rst          in   1      asynchronous, active-high reset
//   start        in   1      1-cycle request to begin a sweep; ignored while busy
//   wt_done      in   1      datapath write-complete (WT_DONE)
//   rd_done      in   1      datapath read-complete (RD_DONE)
//   dram_data    in   128    {DRAM_DATA_OUT16..DRAM_DATA_OUT1}, 8 bits/core
//   io_en        out  1      IO_EN pulse to datapath
//   io_model     out  2      IO_MODEL: 2'b01 write, 2'b10 read, 2'b00 idle
//   wwl_add      out  6      write row address (WWL_ADD)
//   rwl_add      out  6      read row address, broadcast to RWL_DEC_ADD1..16
//   wbl_data     out  64     write data, broadcast to WBL_DATA_IN1..16
//   busy         out  1      sweep in progress
//   done         out  1      1-cycle pulse at sweep end
//   pass         out  1      valid from done until next start: err_cnt==0 and no timeout
//   timeout      out  1      sticky until next start: an operation exceeded TIMEOUT_CYC
//   err_cnt      out  ERR_W  mismatching bytes, saturating
//   cur_addr     out  6      row currently being processed
// BEHAVIOUR
//   Reset values: io_en=0, io_model=0, wwl_add=rwl_add=cur_addr=ADDR_START, wbl_data=0, busy=0,
//     done=0, pass=0, timeout=0, err_cnt=0, and FSM=IDLE. Reset applies immediately mid-sweep; no partial cleanup.
//   Pattern byte: pat = SEED ^ {2'b00,cur_addr}. wbl_data = {8{pat}}. Expected read byte per core = pat.
//   FSM:
//     IDLE: on start, clear err_cnt, timeout and pass; set cur_addr=ADDR_START; busy=1; go to WR_ISSUE.
//     WR_ISSUE (1 cycle): io_en=1, io_model=01, wwl_add=cur_addr, wbl_data=pattern. Reset the timer; go to WR_WAIT.
//     WR_WAIT: io_en=0; io_model, wwl_add and wbl_data are held.
//       wt_done=1 -> RD_ISSUE. Timer reaches TIMEOUT_CYC -> timeout=1, go to FINISH.
//     RD_ISSUE (1 cycle): io_en=1, io_model=10, rwl_add=cur_addr. Reset the timer; go to RD_WAIT.
//     RD_WAIT: io_en=0, outputs held. rd_done=1 -> capture dram_data into a register, go to CHECK.
//       Timer reaches TIMEOUT_CYC -> timeout=1, go to FINISH.
//     CHECK (1 cycle): add the number of the 16 captured bytes that differ from pat (0..16) to err_cnt.
//       err_cnt saturates at 2^ERR_W-1. If cur_addr==ADDR_END go to FINISH; else cur_addr+1, go to WR_ISSUE.
//     FINISH (1 cycle): io_model=00, done=1, busy=0, pass=(err_cnt==0 && !timeout); go to IDLE.
//   Latency: the io_en write pulse occurs the cycle after start is sampled.
//     RD_ISSUE follows the cycle after wt_done; CHECK follows the cycle after rd_done.
//   wt_done/rd_done are sampled only in their own WAIT state. In other states they are ignored.
//     A done already high on entry to WAIT is accepted on the first WAIT cycle.
//   Simultaneous: done and timer expiry in the same cycle -> done wins (no timeout).
//   start while busy is ignored. start in the same cycle as FINISH is ignored.
//   No wrap: cur_addr never increments past ADDR_END; ADDR_START==ADDR_END sweeps one row.
//   Exactly one io_en pulse per operation; io_en is never high in two consecutive cycles.
// TESTING
//   1. Ideal model (wt_done 3 cycles after io_en, echoes pattern), full sweep 0..63:
//      128 io_en pulses; done pulse; pass=1; err_cnt=0.
//   2. Model returns core 5 byte ^8'h01 at row 7 only -> err_cnt=1, pass=0, and all 64 rows still swept.
//   3. rd_done never asserted at row 0, TIMEOUT_CYC=16 -> timeout=1 after 16 RD_WAIT cycles; done; pass=0; cur_addr=0.
//   4. Every core wrong on all 64 rows, ERR_W=10 -> err_cnt saturates at 1023 (not 1024 wrap).
//   5. rst pulsed during RD_WAIT at row 20 -> all outputs at reset values next edge.
//      A new start sweeps from ADDR_START.
//   6. start pulsed mid-sweep, and wt_done pulsed while in RD_WAIT -> no effect on sequence or io_en count.

Source files
------------

// File: rtl/dram_wr_rd_sequencer.sv
// Self-test sequencer for the 16-core DRAM datapath: writes an address-keyed byte
// pattern to every row in a range, reads it back and counts mismatching bytes.
module dram_wr_rd_sequencer #(
    parameter logic [5:0] ADDR_START  = 6'd0,
    parameter logic [5:0] ADDR_END    = 6'd63,
    parameter logic [7:0] SEED        = 8'h55,
    parameter int         TIMEOUT_CYC = 4096,
    parameter int         ERR_W       = 12
) (
    input  logic             clk_100m,
    input  logic             rst,
    input  logic             start,
    input  logic             wt_done,
    input  logic             rd_done,
    input  logic [127:0]     dram_data,
    output logic             io_en,
    output logic [1:0]       io_model,
    output logic [5:0]       wwl_add,
    output logic [5:0]       rwl_add,
    output logic [63:0]      wbl_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [ERR_W-1:0] err_cnt,
    output logic [5:0]       cur_addr
);

    localparam int                  TMR_W    = $clog2(TIMEOUT_CYC + 1);
    localparam int                  ERR_W1   = ERR_W + 1;
    localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [ERR_W:0]      ERR_MAX  = {1'b0, {ERR_W{1'b1}}};
    localparam logic [1:0]          MODEL_IDLE  = 2'b00;
    localparam logic [1:0]          MODEL_WRITE = 2'b01;
    localparam logic [1:0]          MODEL_READ  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ISSUE,
        S_WR_WAIT,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_CHECK,
        S_FINISH
    } state_t;

    state_t             state_reg;
    logic [TMR_W-1:0]   timer_reg;
    logic [127:0]       rd_data_reg;

    logic [7:0]         pat;
    logic [5:0]         addr_inc;
    logic [15:0]        byte_miss;
    logic [4:0]         miss_cnt;
    logic [ERR_W:0]     err_sum;
    logic [ERR_W-1:0]   err_next;

    function automatic logic [63:0] pat_word(input logic [5:0] addr);
        return {8{SEED ^ {2'b00, addr}}};
    endfunction

    assign pat      = SEED ^ {2'b00, cur_addr};
    assign addr_inc = cur_addr + 6'd1;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_core
            assign byte_miss[gi] = (rd_data_reg[gi*8 +: 8] != pat);
        end
    endgenerate

    // Extra top bit on the sum lets saturation be detected without wrapping.
    always_comb begin
        miss_cnt = '0;
        for (int i = 0; i < 16; i++) begin
            miss_cnt = miss_cnt + {4'd0, byte_miss[i]};
        end
        err_sum  = {1'b0, err_cnt} + ERR_W1'(miss_cnt);
        err_next = (err_sum > ERR_MAX) ? ERR_MAX[ERR_W-1:0] : err_sum[ERR_W-1:0];
    end

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            timer_reg   <= '0;
            rd_data_reg <= '0;
            io_en       <= 1'b0;
            io_model    <= MODEL_IDLE;
            wwl_add     <= ADDR_START;
            rwl_add     <= ADDR_START;
            wbl_data    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            err_cnt     <= '0;
            cur_addr    <= ADDR_START;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        err_cnt   <= '0;
                        timeout   <= 1'b0;
                        pass      <= 1'b0;
                        cur_addr  <= ADDR_START;
                        busy      <= 1'b1;
                        io_en     <= 1'b1;
                        io_model  <= MODEL_WRITE;
                        wwl_add   <= ADDR_START;
                        wbl_data  <= pat_word(ADDR_START);
                        state_reg <= S_WR_ISSUE;
                    end
                end

                S_WR_ISSUE: begin
                    io_en     <= 1'b0;
                    timer_reg <= '0;
                    state_reg <= S_WR_WAIT;
                end

                // Completion is tested before expiry so a coincident done wins.
                S_WR_WAIT: begin
                    if (wt_done) begin
                        io_en     <= 1'b1;
                        io_model  <= MODEL_READ;
                        rwl_add   <= cur_addr;
                        state_reg <= S_RD_ISSUE;
                    end else if (timer_reg == TMR_LAST) begin
                        timeout   <= 1'b1;
                        io_model  <= MODEL_IDLE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        pass      <= 1'b0;
                        state_reg <= S_FINISH;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end

                S_RD_ISSUE: begin
                    io_en     <= 1'b0;
                    timer_reg <= '0;
                    state_reg <= S_RD_WAIT;
                end

                S_RD_WAIT: begin
                    if (rd_done) begin
                        rd_data_reg <= dram_data;
                        state_reg   <= S_CHECK;
                    end else if (timer_reg == TMR_LAST) begin
                        timeout   <= 1'b1;
                        io_model  <= MODEL_IDLE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        pass      <= 1'b0;
                        state_reg <= S_FINISH;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end

                S_CHECK: begin
                    err_cnt <= err_next;
                    if (cur_addr == ADDR_END) begin
                        io_model  <= MODEL_IDLE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        pass      <= (err_next == '0) && !timeout;
                        state_reg <= S_FINISH;
                    end else begin
                        cur_addr  <= addr_inc;
                        io_en     <= 1'b1;
                        io_model  <= MODEL_WRITE;
                        wwl_add   <= addr_inc;
                        wbl_data  <= pat_word(addr_inc);
                        state_reg <= S_WR_ISSUE;
                    end
                end

                S_FINISH: begin
                    done      <= 1'b0;
                    state_reg <= S_IDLE;
                end

                default: begin
                    io_en     <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_wr_rd_sequencer.sv
// Directed bench: a behavioural 16-core datapath echoes written bytes with optional
// fault injection; each sweep result is compared against hand-computed values.
module tb_dram_wr_rd_sequencer;

    logic         clk_100m = 1'b0;
    logic         rst;
    logic         start;
    logic         wt_done;
    logic         rd_done;
    logic [127:0] dram_data;
    logic         io_en;
    logic [1:0]   io_model;
    logic [5:0]   wwl_add;
    logic [5:0]   rwl_add;
    logic [63:0]  wbl_data;
    logic         busy;
    logic         done;
    logic         pass;
    logic         timeout;
    logic [9:0]   err_cnt;
    logic [5:0]   cur_addr;

    int checks   = 0;
    int failures = 0;

    // datapath model controls
    int   err_row   = -1;
    bit   all_wrong = 1'b0;
    bit   hang_rd   = 1'b0;
    int   hang_row  = 0;
    logic inj_wt    = 1'b0;

    logic       wt_done_m, rd_done_m;
    logic [2:0] wr_cd, rd_cd;
    logic [5:0] rd_addr;
    logic [7:0] mem [0:63];
    int         io_en_cnt = 0;
    int         b2b_cnt   = 0;
    logic       prev_io_en = 1'b0;

    always #5 clk_100m = ~clk_100m;

    assign wt_done = wt_done_m | inj_wt;
    assign rd_done = rd_done_m;

    dram_wr_rd_sequencer #(
        .ADDR_START (6'd0),
        .ADDR_END   (6'd63),
        .SEED       (8'h55),
        .TIMEOUT_CYC(16),
        .ERR_W      (10)
    ) dut (
        .clk_100m (clk_100m),
        .rst      (rst),
        .start    (start),
        .wt_done  (wt_done),
        .rd_done  (rd_done),
        .dram_data(dram_data),
        .io_en    (io_en),
        .io_model (io_model),
        .wwl_add  (wwl_add),
        .rwl_add  (rwl_add),
        .wbl_data (wbl_data),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .timeout  (timeout),
        .err_cnt  (err_cnt),
        .cur_addr (cur_addr)
    );

    function automatic logic [127:0] read_word(input logic [5:0] a);
        logic [127:0] w;
        logic [7:0]   b;
        w = '0;
        for (int c = 0; c < 16; c++) begin
            b = mem[a];
            if (all_wrong) b = b ^ 8'hFF;
            if (err_row == int'(a) && c == 5) b = b ^ 8'h01;
            w[c*8 +: 8] = b;
        end
        return w;
    endfunction

    always @(posedge clk_100m) begin
        if (io_en && io_model == 2'b01) mem[wwl_add] <= wbl_data[7:0];
    end

    always @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            wt_done_m <= 1'b0;
            rd_done_m <= 1'b0;
            wr_cd     <= '0;
            rd_cd     <= '0;
            rd_addr   <= '0;
            dram_data <= '0;
        end else begin
            wt_done_m <= 1'b0;
            rd_done_m <= 1'b0;
            if (wr_cd != 0) begin
                wr_cd <= wr_cd - 1'b1;
                if (wr_cd == 1) wt_done_m <= 1'b1;
            end
            if (rd_cd != 0) begin
                rd_cd <= rd_cd - 1'b1;
                if (rd_cd == 1) begin
                    rd_done_m <= 1'b1;
                    dram_data <= read_word(rd_addr);
                end
            end
            if (io_en && io_model == 2'b01) wr_cd <= 3'd3;
            if (io_en && io_model == 2'b10) begin
                rd_addr <= rwl_add;
                if (!(hang_rd && int'(rwl_add) == hang_row)) rd_cd <= 3'd3;
            end
        end
    end

    always @(posedge clk_100m) begin
        prev_io_en <= io_en;
        if (io_en) io_en_cnt <= io_en_cnt + 1;
        if (io_en && prev_io_en) b2b_cnt <= b2b_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk_100m);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (!done && n < limit) begin
            @(negedge clk_100m);
            n++;
        end
        chk("done_seen", {63'd0, done}, 64'd1);
    endtask

    task automatic wait_rd_issue(input logic [5:0] row);
        int n;
        n = 0;
        while (!(io_en && io_model == 2'b10 && rwl_add == row) && n < 2000) begin
            @(negedge clk_100m);
            n++;
        end
        chk("rd_issue_seen", {58'd0, rwl_add}, {58'd0, row});
    endtask

    initial begin
        int base, n;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk_100m);
        chk("rst_io_en",    {63'd0, io_en},    64'd0);
        chk("rst_io_model", {62'd0, io_model}, 64'd0);
        chk("rst_wwl_add",  {58'd0, wwl_add},  64'd0);
        chk("rst_rwl_add",  {58'd0, rwl_add},  64'd0);
        chk("rst_wbl_data", wbl_data,          64'd0);
        chk("rst_busy",     {63'd0, busy},     64'd0);
        chk("rst_done",     {63'd0, done},     64'd0);
        chk("rst_pass",     {63'd0, pass},     64'd0);
        chk("rst_timeout",  {63'd0, timeout},  64'd0);
        chk("rst_err_cnt",  {54'd0, err_cnt},  64'd0);
        chk("rst_cur_addr", {58'd0, cur_addr}, 64'd0);
        rst = 1'b0;
        @(negedge clk_100m);

        // 1: ideal full sweep
        base = io_en_cnt;
        pulse_start();
        chk("t1_lat_io_en",    {63'd0, io_en},    64'd1);
        chk("t1_lat_io_model", {62'd0, io_model}, 64'd1);
        chk("t1_first_wbl",    wbl_data,          64'h5555555555555555);
        chk("t1_busy",         {63'd0, busy},     64'd1);
        wait_done(5000);
        chk("t1_pass",     {63'd0, pass},     64'd1);
        chk("t1_err",      {54'd0, err_cnt},  64'd0);
        chk("t1_timeout",  {63'd0, timeout},  64'd0);
        chk("t1_busy_end", {63'd0, busy},     64'd0);
        chk("t1_cur_addr", {58'd0, cur_addr}, 64'd63);
        chk("t1_last_wbl", wbl_data,          64'h6a6a6a6a6a6a6a6a);
        chk("t1_io_model", {62'd0, io_model}, 64'd0);
        chk("t1_io_en_cnt", 64'(io_en_cnt - base), 64'd128);
        @(negedge clk_100m);
        chk("t1_done_pulse", {63'd0, done}, 64'd0);
        chk("t1_pass_held",  {63'd0, pass}, 64'd1);
        $display("sweep 1 ideal: err_cnt=%0d pass=%0b", err_cnt, pass);

        // 2: single-byte fault on core 5 at row 7
        err_row = 7;
        base = io_en_cnt;
        pulse_start();
        wait_done(5000);
        chk("t2_err",      {54'd0, err_cnt},  64'd1);
        chk("t2_pass",     {63'd0, pass},     64'd0);
        chk("t2_cur_addr", {58'd0, cur_addr}, 64'd63);
        chk("t2_io_en_cnt", 64'(io_en_cnt - base), 64'd128);
        $display("sweep 2 row7 fault: err_cnt=%0d pass=%0b", err_cnt, pass);
        err_row = -1;
        @(negedge clk_100m);

        // 3: read hangs at row 0
        hang_rd = 1'b1;
        hang_row = 0;
        pulse_start();
        wait_rd_issue(6'd0);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk_100m);
            n++;
        end
        chk("t3_done_lat",  64'(n),            64'd17);
        chk("t3_timeout",   {63'd0, timeout},  64'd1);
        chk("t3_pass",      {63'd0, pass},     64'd0);
        chk("t3_cur_addr",  {58'd0, cur_addr}, 64'd0);
        chk("t3_busy",      {63'd0, busy},     64'd0);
        $display("sweep 3 read hang: timeout=%0b after %0d cycles", timeout, n);
        hang_rd = 1'b0;
        @(negedge clk_100m);
        chk("t3_timeout_sticky", {63'd0, timeout}, 64'd1);

        // 4: every byte wrong, counter must saturate
        all_wrong = 1'b1;
        pulse_start();
        chk("t4_timeout_cleared", {63'd0, timeout}, 64'd0);
        wait_done(5000);
        chk("t4_err_sat",  {54'd0, err_cnt}, 64'd1023);
        chk("t4_pass",     {63'd0, pass},    64'd0);
        chk("t4_timeout",  {63'd0, timeout}, 64'd0);
        $display("sweep 4 all wrong: err_cnt=%0d", err_cnt);
        all_wrong = 1'b0;
        @(negedge clk_100m);

        // 5: reset during RD_WAIT at row 20, then restart
        pulse_start();
        wait_rd_issue(6'd20);
        @(negedge clk_100m);
        rst = 1'b1;
        @(negedge clk_100m);
        chk("t5_busy",     {63'd0, busy},     64'd0);
        chk("t5_cur_addr", {58'd0, cur_addr}, 64'd0);
        chk("t5_rwl_add",  {58'd0, rwl_add},  64'd0);
        chk("t5_wwl_add",  {58'd0, wwl_add},  64'd0);
        chk("t5_io_model", {62'd0, io_model}, 64'd0);
        chk("t5_wbl_data", wbl_data,          64'd0);
        rst = 1'b0;
        @(negedge clk_100m);
        base = io_en_cnt;
        pulse_start();
        chk("t5_restart_io_en", {63'd0, io_en},   64'd1);
        chk("t5_restart_wwl",   {58'd0, wwl_add}, 64'd0);
        wait_done(5000);
        chk("t5_pass",      {63'd0, pass}, 64'd1);
        chk("t5_io_en_cnt", 64'(io_en_cnt - base), 64'd128);
        $display("sweep 5 reset+restart: pass=%0b", pass);
        @(negedge clk_100m);

        // 6: stray start and wt_done during RD_WAIT at row 10
        base = io_en_cnt;
        pulse_start();
        wait_rd_issue(6'd10);
        chk("t6_wbl_row10", wbl_data, 64'h5f5f5f5f5f5f5f5f);
        @(negedge clk_100m);
        inj_wt = 1'b1;
        start  = 1'b1;
        @(negedge clk_100m);
        inj_wt = 1'b0;
        start  = 1'b0;
        chk("t6_io_en_quiet", {63'd0, io_en}, 64'd0);
        wait_done(5000);
        chk("t6_pass",      {63'd0, pass},     64'd1);
        chk("t6_cur_addr",  {58'd0, cur_addr}, 64'd63);
        chk("t6_io_en_cnt", 64'(io_en_cnt - base), 64'd128);
        $display("sweep 6 stray start/wt_done: pass=%0b", pass);
        @(negedge clk_100m);
        chk("no_b2b_io_en", 64'(b2b_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
